// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - pad input conditioner: sync, debounce, edge latch, IRQ
//
// Purpose: synchronises raw pad inputs, debounces each bit into gpio_in_clean,
// latches enabled rise/fall edges of the clean vector in a write-1-to-clear
// STATUS register and drives a maskable, registered level interrupt.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   wb_adr[23:0]    word address          wb_cyc, wb_stb, wb_we  bus controls
//   wb_i_dat[15:0]  write data            wb_o_dat[15:0]         read data (comb)
//   wb_ack          = wb_cyc & wb_stb (no wait states)
//   pad_in[N-1:0]   raw asynchronous pad inputs
//   gpio_in_clean   debounced inputs toward the GPIO block
//   o_irq           registered interrupt request, level
//
// Register map (word addresses):
//   0x001014 STATUS R/W1C   0x001015 MASK    RW   0x001016 RISE_EN RW
//   0x001017 FALL_EN RW     0x001018 DB_PERIOD RW 0x001019 CLEAN   RO
module gpio_in_cond #(
  parameter int          N           = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          DB_W        = 8,
  parameter int unsigned DB_RESET    = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [23:0]   wb_adr,
  input  logic          wb_cyc,
  input  logic          wb_stb,
  input  logic          wb_we,
  input  logic [15:0]   wb_i_dat,
  output logic [15:0]   wb_o_dat,
  output logic          wb_ack,
  input  logic [N-1:0]  pad_in,
  output logic [N-1:0]  gpio_in_clean,
  output logic          o_irq
);

  localparam logic [23:0] ADDR_STATUS  = 24'h001014;
  localparam logic [23:0] ADDR_MASK    = 24'h001015;
  localparam logic [23:0] ADDR_RISE_EN = 24'h001016;
  localparam logic [23:0] ADDR_FALL_EN = 24'h001017;
  localparam logic [23:0] ADDR_DB      = 24'h001018;
  localparam logic [23:0] ADDR_CLEAN   = 24'h001019;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N-1:0]    sync_q [SYNC_STAGES];
  logic [DB_W-1:0] cnt_q  [N];
  logic [DB_W-1:0] cnt_d  [N];
  logic [N-1:0]    clean_q,   clean_d;
  logic [N-1:0]    status_q,  status_d;
  logic [N-1:0]    mask_q,    mask_d;
  logic [N-1:0]    rise_en_q, rise_en_d;
  logic [N-1:0]    fall_en_q, fall_en_d;
  logic [DB_W-1:0] db_period_q, db_period_d;
  logic            irq_q,     irq_d;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic bus_sel;
  logic bus_wr;
  logic unused_wdat;

  assign bus_sel = wb_cyc & wb_stb;
  assign bus_wr  = bus_sel & wb_we;
  assign wb_ack  = bus_sel;

  // Upper write-data bits beyond N / DB_W have no destination.
  assign unused_wdat = ^wb_i_dat;

  // ---------------------------------------------------------------------------
  // Debounce and edge detection
  // ---------------------------------------------------------------------------
  logic [N-1:0] s;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    clean_d = clean_q;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s[i] != clean_q[i]) begin
        // >= (not ==) so that shrinking DB_PERIOD below a running count
        // still resolves on the next mismatching cycle.
        if (cnt_q[i] >= db_period_q) begin
          clean_d[i] = s[i];
          rise[i]    = s[i];
          fall[i]    = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------------
  logic [N-1:0] status_set;
  logic [N-1:0] status_clr;

  always_comb begin
    status_set = (rise & rise_en_q) | (fall & fall_en_q);
    status_clr = (bus_wr && wb_adr == ADDR_STATUS) ? wb_i_dat[N-1:0] : '0;
    // A new edge in the same cycle as its clear keeps the bit set.
    status_d   = (status_q & ~status_clr) | status_set;

    mask_d      = (bus_wr && wb_adr == ADDR_MASK)    ? wb_i_dat[N-1:0]    : mask_q;
    rise_en_d   = (bus_wr && wb_adr == ADDR_RISE_EN) ? wb_i_dat[N-1:0]    : rise_en_q;
    fall_en_d   = (bus_wr && wb_adr == ADDR_FALL_EN) ? wb_i_dat[N-1:0]    : fall_en_q;
    db_period_d = (bus_wr && wb_adr == ADDR_DB)      ? wb_i_dat[DB_W-1:0] : db_period_q;

    irq_d = |(status_q & mask_q);
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      clean_q     <= '0;
      status_q    <= '0;
      mask_q      <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      db_period_q <= DB_W'(DB_RESET);
      irq_q       <= 1'b0;
    end else begin
      sync_q[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      clean_q     <= clean_d;
      status_q    <= status_d;
      mask_q      <= mask_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      db_period_q <= db_period_d;
      irq_q       <= irq_d;
    end
  end

  assign gpio_in_clean = clean_q;
  assign o_irq         = irq_q;

  // ---------------------------------------------------------------------------
  // Read mux (combinational, side-effect free)
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_o_dat = '0;
    case (wb_adr)
      ADDR_STATUS:  wb_o_dat[N-1:0]    = status_q;
      ADDR_MASK:    wb_o_dat[N-1:0]    = mask_q;
      ADDR_RISE_EN: wb_o_dat[N-1:0]    = rise_en_q;
      ADDR_FALL_EN: wb_o_dat[N-1:0]    = fall_en_q;
      ADDR_DB:      wb_o_dat[DB_W-1:0] = db_period_q;
      ADDR_CLEAN:   wb_o_dat[N-1:0]    = clean_q;
      default:      wb_o_dat           = '0;
    endcase
  end

endmodule
